wire_label_engine: RTL
======================

Name: wire_label_engine

Overview:
- Parametrised garbled-circuit wire-label controller. Owns the label store (single-port synchronous RAM, 2**ADDR_W entries of LABEL_W bits) and a global free-XOR offset register (delta).
- Accepts one command at a time over a valid/ready interface: fetch one label, fetch a pair, store a label, or load delta.
- Returns the combined gate-input label and the point-and-permute pointer over a valid/ready response interface.
- Sits between the gate sequencer and the AES garbling/evaluation core.

Parameters:
- LABEL_W, 128: label width in bits; must be >= 2.
- ID_W, 24: wire-ID width on the command interface.
- ADDR_W, 13: RAM address width. Depth is 2**ADDR_W. Address is id[ADDR_W-1:0]. ADDR_W <= ID_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid & ready
- cmd_op  in  2  0 FETCH1, 1 FETCH2, 2 STORE, 3 SET_DELTA
- cmd_gate  in  2  0 AND, 1 XOR, 2 BUF, 3 INV
- cmd_id_a  in  ID_W  first wire ID; the STORE target
- cmd_id_b  in  ID_W  second wire ID (FETCH2 only)
- cmd_label  in  LABEL_W  STORE data / SET_DELTA value
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid & ready
- rsp_label  out  LABEL_W  result label
- rsp_point  out  2  point-and-permute pointer
- rsp_err  out  1  error flag (see Optional Feature)

Behaviour:
- Interface decisions:
  - Reset rst is synchronous and active-high; clock is clk.
  - Every accepted command produces exactly one response.
- Reset values: cmd_ready 0 during rst and 1 in the first cycle after; rsp_valid 0, rsp_label 0, rsp_point 0, rsp_err 0, delta 0, state IDLE.
- Reset does not clear RAM contents. Reset mid-operation aborts the command, drops any pending response, and skips any RAM write not yet issued.
- cmd_ready = (state == IDLE) & ~rst. Command fields are latched on accept.
- rsp_valid, rsp_label, rsp_point and rsp_err are held stable until rsp_ready. The handshake returns the engine to IDLE, so there is a one-cycle bubble before the next accept.
- States: IDLE, RD_A, RD_B, CAP_B, WR, RESP.
- FETCH1 path: IDLE -> RD_A (issue read of A) -> CAP_B (capture A) -> RESP.
- FETCH2 path: IDLE -> RD_A -> RD_B (capture A, issue read of B) -> CAP_B (capture B, combine) -> RESP.
- STORE path: IDLE -> WR (RAM write) -> RESP.
- SET_DELTA path: IDLE -> RESP.
- Latency from the accept edge to rsp_valid high: FETCH1 3 cycles, FETCH2 4, STORE 2, SET_DELTA 1.
- Combine rules (A = label at id_a, B = label at id_b):
  - FETCH2 AND: label = {(A^B)[LABEL_W-1:1], 1'b0}; point = {A[0], B[0]}.
  - FETCH2 XOR: label = A^B; point = {A[0], B[0]}.
  - FETCH2 with BUF/INV: treated as XOR.
  - FETCH1 BUF: label = A; point = {1'b0, A[0]}.
  - FETCH1 INV: label = A^delta; point = {1'b0, A[0]^delta[0]}.
  - FETCH1 with AND/XOR: treated as BUF.
- STORE: RAM[id_a] <= cmd_label in state WR. Response echoes the label; point 0.
- SET_DELTA: delta <= {cmd_label[LABEL_W-1:1], 1'b1}, so bit 0 is forced to 1. Response echoes the new delta; point 0.
- FETCH2 with id_a == id_b is legal: both reads return the same label, so XOR yields 0.
- A read following a store to the same address returns the new data; the RAM write completes before any later read can be issued.

Optional Feature:
- Macro: WIRE_LABEL_ENGINE_VALID_EN.
- With the macro defined:
  - A 2**ADDR_W-bit written-bitmap is cleared by rst and set on each STORE.
  - A FETCH of a never-written address sets rsp_err=1. The label is still computed from RAM contents.
  - Any cmd_id with nonzero bits above ADDR_W sets rsp_err=1 and suppresses a STORE write.
- Without the macro: no bitmap; upper ID bits are ignored; rsp_err is tied 0.

Decomposition:
- Package gc_pkg holds:
  - opcode localparams: OP_FETCH1, OP_FETCH2, OP_STORE, OP_SET_DELTA;
  - gate localparams: GATE_AND, GATE_XOR, GATE_BUF, GATE_INV;
  - FSM state encodings.
- One sub-module: label_ram. It is a single-port synchronous RAM (ADDR_W, LABEL_W), write-enable, one-cycle read latency, no reset.

Test Plan:
- STORE id 5 = 0x...A1, then FETCH1 BUF id 5 -> rsp_label 0x...A1, rsp_point 2'b01, rsp_valid exactly 3 cycles after accept.
- STORE id 1 = 0x0F (bit0 1), STORE id 2 = 0xF2 (bit0 0). FETCH2 XOR -> 0xFD, point 2'b10. FETCH2 AND -> 0xFC, point 2'b10, latency 4.
- SET_DELTA 0x80 -> echo 0x81, latency 1. FETCH1 INV id 1 (0x0F) -> 0x8E, point 2'b00.
- Hold rsp_ready=0 for 5 cycles -> response stable and cmd_ready 0 throughout. The next command is accepted one cycle after the handshake.
- Assert rst while in RD_B -> rsp_valid 0 next cycle, delta 0. Previously stored label id 1 still reads back 0x0F.
- With the macro: FETCH1 of unwritten id 7 -> rsp_err 1. STORE to id 0x2000 (ADDR_W=13) -> rsp_err 1, and id 0 is unchanged.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared opcode, gate-type and FSM state encodings for the wire-label engine.
package gc_pkg;

    localparam logic [1:0] OP_FETCH1    = 2'd0;
    localparam logic [1:0] OP_FETCH2    = 2'd1;
    localparam logic [1:0] OP_STORE     = 2'd2;
    localparam logic [1:0] OP_SET_DELTA = 2'd3;

    localparam logic [1:0] GATE_AND = 2'd0;
    localparam logic [1:0] GATE_XOR = 2'd1;
    localparam logic [1:0] GATE_BUF = 2'd2;
    localparam logic [1:0] GATE_INV = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_A  = 3'd1;
    localparam logic [2:0] ST_RD_B  = 3'd2;
    localparam logic [2:0] ST_CAP_B = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

endpackage

// File: rtl/label_ram.sv
// Single-port synchronous label store: one-cycle read latency, no reset, write-enable.
module label_ram #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned LABEL_W = 128
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [LABEL_W-1:0] wdata,
    output logic [LABEL_W-1:0] rdata
);

    logic [LABEL_W-1:0] mem_q [2**ADDR_W];
    logic [LABEL_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wire_label_engine.sv
// Garbled-circuit wire-label controller: label RAM, free-XOR delta and gate-input combine.
// Optional written-bitmap / ID range checking is enabled by WIRE_LABEL_ENGINE_VALID_EN.
module wire_label_engine #(
    parameter int unsigned LABEL_W = 128,
    parameter int unsigned ID_W    = 24,
    parameter int unsigned ADDR_W  = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [1:0]         cmd_gate,
    input  logic [ID_W-1:0]    cmd_id_a,
    input  logic [ID_W-1:0]    cmd_id_b,
    input  logic [LABEL_W-1:0] cmd_label,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [LABEL_W-1:0] rsp_label,
    output logic [1:0]         rsp_point,
    output logic               rsp_err
);
    import gc_pkg::*;

    logic [2:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         gate_q, gate_d;
    logic [ID_W-1:0]    id_a_q, id_a_d;
    logic [ID_W-1:0]    id_b_q, id_b_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [LABEL_W-1:0] a_q, a_d;
    logic [LABEL_W-1:0] delta_q, delta_d;
    logic [LABEL_W-1:0] rsp_label_q, rsp_label_d;
    logic [1:0]         rsp_point_q, rsp_point_d;
    logic               rsp_err_q, rsp_err_d;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [LABEL_W-1:0] ram_rdata;
    logic [LABEL_W-1:0] pair_x;
    logic               fetch_err;
    logic               store_err;

    logic [ADDR_W-1:0]  addr_a;
    logic [ADDR_W-1:0]  addr_b;

    assign addr_a = id_a_q[ADDR_W-1:0];
    assign addr_b = id_b_q[ADDR_W-1:0];
    assign pair_x = a_q ^ ram_rdata;

`ifdef WIRE_LABEL_ENGINE_VALID_EN
    logic [2**ADDR_W-1:0] written_q, written_d;
    logic                 hi_a, hi_b;

    assign hi_a      = (id_a_q >> ADDR_W) != '0;
    assign hi_b      = (id_b_q >> ADDR_W) != '0;
    assign store_err = hi_a;
    assign fetch_err = hi_a | ~written_q[addr_a]
                     | ((op_q == OP_FETCH2) & (hi_b | ~written_q[addr_b]));

    always_comb begin
        written_d = written_q;
        if (state_q == ST_WR && !store_err) begin
            written_d[addr_a] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end
`else
    logic unused_id_hi;
    assign unused_id_hi = ^{id_a_q, id_b_q};
    assign fetch_err    = 1'b0;
    assign store_err    = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE) & ~rst;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_label = rsp_label_q;
    assign rsp_point = rsp_point_q;
    assign rsp_err   = rsp_err_q;

    // RAM has no reset, so a write pending in WR must be gated off by rst directly.
    assign ram_we = (state_q == ST_WR) & ~rst & ~store_err;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        gate_d      = gate_q;
        id_a_d      = id_a_q;
        id_b_d      = id_b_q;
        label_d     = label_q;
        a_d         = a_q;
        delta_d     = delta_q;
        rsp_label_d = rsp_label_q;
        rsp_point_d = rsp_point_q;
        rsp_err_d   = rsp_err_q;
        ram_addr    = addr_a;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    gate_d  = cmd_gate;
                    id_a_d  = cmd_id_a;
                    id_b_d  = cmd_id_b;
                    label_d = cmd_label;
                    case (cmd_op)
                        OP_FETCH1, OP_FETCH2: state_d = ST_RD_A;
                        OP_STORE:             state_d = ST_WR;
                        default: begin
                            delta_d     = {cmd_label[LABEL_W-1:1], 1'b1};
                            rsp_label_d = {cmd_label[LABEL_W-1:1], 1'b1};
                            rsp_point_d = 2'b00;
                            rsp_err_d   = 1'b0;
                            state_d     = ST_RESP;
                        end
                    endcase
                end
            end
            ST_RD_A: begin
                state_d = (op_q == OP_FETCH2) ? ST_RD_B : ST_CAP_B;
            end
            ST_RD_B: begin
                a_d      = ram_rdata;
                ram_addr = addr_b;
                state_d  = ST_CAP_B;
            end
            ST_CAP_B: begin
                if (op_q == OP_FETCH2) begin
                    rsp_label_d = pair_x;
                    if (gate_q == GATE_AND) begin
                        rsp_label_d[0] = 1'b0;
                    end
                    rsp_point_d = {a_q[0], ram_rdata[0]};
                end else if (gate_q == GATE_INV) begin
                    rsp_label_d = ram_rdata ^ delta_q;
                    rsp_point_d = {1'b0, ram_rdata[0] ^ delta_q[0]};
                end else begin
                    rsp_label_d = ram_rdata;
                    rsp_point_d = {1'b0, ram_rdata[0]};
                end
                rsp_err_d = fetch_err;
                state_d   = ST_RESP;
            end
            ST_WR: begin
                rsp_label_d = label_q;
                rsp_point_d = 2'b00;
                rsp_err_d   = store_err;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            gate_q      <= '0;
            id_a_q      <= '0;
            id_b_q      <= '0;
            label_q     <= '0;
            a_q         <= '0;
            delta_q     <= '0;
            rsp_label_q <= '0;
            rsp_point_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            gate_q      <= gate_d;
            id_a_q      <= id_a_d;
            id_b_q      <= id_b_d;
            label_q     <= label_d;
            a_q         <= a_d;
            delta_q     <= delta_d;
            rsp_label_q <= rsp_label_d;
            rsp_point_q <= rsp_point_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    label_ram #(
        .ADDR_W  (ADDR_W),
        .LABEL_W (LABEL_W)
    ) u_label_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (label_q),
        .rdata (ram_rdata)
    );

endmodule
